// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit for the ID stage.
// Each architectural register r (r != 0) has a countdown cnt[r]. It holds the
// number of cycles until the register's pending result can be forwarded to an
// EXE consumer, with a BR_EXTRA bias for branches that resolve in ID. The
// all-ones code (STICKY) marks a variable-latency producer. Such a register
// stays busy until a writeback release arrives.
module scoreboard_hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int SRC_NUM    = 2,
   parameter int LAT_W      = 3,
   parameter int BR_EXTRA   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          id_valid,
   input  logic [SRC_NUM*REG_ADDR_W-1:0] id_src_addr,
   input  logic [SRC_NUM-1:0]            id_src_used,
   input  logic                          id_is_branch,
   input  logic                          id_wreg,
   input  logic [REG_ADDR_W-1:0]         id_dst_addr,
   input  logic [LAT_W-1:0]              id_lat,
   input  logic                          wb_valid,
   input  logic [REG_ADDR_W-1:0]         wb_addr,
   input  logic                          flush,
   output logic                          stall,
   output logic                          stall_raw,
   output logic                          stall_waw,
   output logic [REG_ADDR_W:0]           long_busy_cnt
);

   localparam int NREG = 1 << REG_ADDR_W;
   localparam logic [LAT_W-1:0] STICKY     = {LAT_W{1'b1}};
   localparam logic [LAT_W-1:0] STICKY_M1  = STICKY - LAT_W'(1);
   localparam logic [LAT_W:0]   BR_EXTRA_W = (LAT_W+1)'(BR_EXTRA);

   logic [LAT_W-1:0]    cnt_q [NREG];
   logic [LAT_W-1:0]    cnt_d [NREG];
   logic [REG_ADDR_W:0] busy_q;
   logic [REG_ADDR_W:0] busy_d;

   logic [SRC_NUM-1:0]  src_hit_s;
   logic                waw_hit_s;
   logic                stall_s;
   logic                issue_s;
   logic                rec_s;
   logic [LAT_W:0]      lat_ext_s;
   logic [LAT_W-1:0]    rec_val_s;

   // Per-operand RAW check. A branch waits for a zero count. An EXE consumer
   // can take forwarding once the count has fallen to BR_EXTRA.
   for (genvar k = 0; k < SRC_NUM; k++) begin : g_src
      logic [REG_ADDR_W-1:0] addr_s;
      logic [LAT_W-1:0]      cnt_sel_s;
      logic                  pend_s;
      assign addr_s    = id_src_addr[k*REG_ADDR_W +: REG_ADDR_W];
      assign cnt_sel_s = cnt_q[addr_s];
      assign pend_s    = id_is_branch ? (cnt_sel_s != '0)
                                      : ({1'b0, cnt_sel_s} > BR_EXTRA_W);
      assign src_hit_s[k] = id_src_used[k] & (addr_s != '0) & pend_s;
   end

   // The stall flags are held at 0 while reset is asserted, in addition to the counters being cleared.
   assign waw_hit_s = id_wreg & (id_dst_addr != '0) & (cnt_q[id_dst_addr] == STICKY);
   assign stall_raw = rst_n & id_valid & (|src_hit_s);
   assign stall_waw = rst_n & id_valid & waw_hit_s;
   assign stall_s   = stall_raw | stall_waw;
   assign stall     = stall_s;

   assign issue_s = id_valid & ~stall_s & ~flush;
   assign rec_s   = issue_s & id_wreg & (id_dst_addr != '0);

   // The recorded latency saturates just below STICKY, so a fixed-latency producer can never become sticky.
   always_comb begin
      lat_ext_s = {1'b0, id_lat} + BR_EXTRA_W;
      if (id_lat == STICKY) begin
         rec_val_s = STICKY;
      end else if (lat_ext_s > {1'b0, STICKY_M1}) begin
         rec_val_s = STICKY_M1;
      end else begin
         rec_val_s = lat_ext_s[LAT_W-1:0];
      end
   end

   // Next-state counters. Priority is flush, then issue, then release, then
   // countdown. The same loop counts the registers that will be sticky.
   always_comb begin
      busy_d = '0;
      for (int r = 0; r < NREG; r++) begin
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (flush) begin
            cnt_d[r] = '0;
         end else if (rec_s && (id_dst_addr == REG_ADDR_W'(r))) begin
            cnt_d[r] = rec_val_s;
         end else if (wb_valid && (wb_addr == REG_ADDR_W'(r)) && (cnt_q[r] == STICKY)) begin
            cnt_d[r] = '0;
         end else if (cnt_q[r] == STICKY) begin
            cnt_d[r] = STICKY;
         end else if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - LAT_W'(1);
         end else begin
            cnt_d[r] = '0;
         end
         if (cnt_d[r] == STICKY) begin
            busy_d = busy_d + (REG_ADDR_W+1)'(1);
         end else begin
            busy_d = busy_d;
         end
      end
   end

   // Counter array and sticky-count register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         busy_q <= busy_d;
      end
   end

   assign long_busy_cnt = busy_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit. It runs a default instance and a
// parameter-swept instance, and checks both against a timestamp-based model.
module tb_scoreboard_hazard_unit;

   typedef struct packed {
      logic            valid;
      logic [2:0][5:0] src;
      logic [2:0]      used;
      logic            br;
      logic            wreg;
      logic [5:0]      dst;
      logic [3:0]      lat;
      logic            wbv;
      logic [5:0]      wba;
      logic            fl;
   } in_t;

   logic clk;
   logic rst_n;
   in_t  in_v [2];

   // DUT0 signals: default parameters
   logic [9:0]  d0_src;
   logic [4:0]  d0_dst, d0_wba;
   logic [2:0]  d0_lat;
   logic        s0_stall, s0_raw, s0_waw;
   logic [5:0]  s0_busy;
   // DUT1 signals: REG_ADDR_W=6, SRC_NUM=3, LAT_W=4, BR_EXTRA=2
   logic        s1_stall, s1_raw, s1_waw;
   logic [6:0]  s1_busy;

   int AW [2] = '{5, 6};
   int SN [2] = '{2, 3};
   int LW [2] = '{3, 4};
   int BX [2] = '{1, 2};

   // Model: the absolute cycle at which each register becomes free, plus a flag for variable-latency producers.
   int ready  [2][64];
   bit sticky [2][64];
   int cyc;
   int nchk;
   int nerr;

   always_comb begin
      d0_src = {in_v[0].src[1][4:0], in_v[0].src[0][4:0]};
      d0_dst = in_v[0].dst[4:0];
      d0_wba = in_v[0].wba[4:0];
      d0_lat = in_v[0].lat[2:0];
   end

   scoreboard_hazard_unit u_dut0 (
      .clk(clk), .rst_n(rst_n), .id_valid(in_v[0].valid), .id_src_addr(d0_src),
      .id_src_used(in_v[0].used[1:0]), .id_is_branch(in_v[0].br), .id_wreg(in_v[0].wreg),
      .id_dst_addr(d0_dst), .id_lat(d0_lat), .wb_valid(in_v[0].wbv), .wb_addr(d0_wba),
      .flush(in_v[0].fl), .stall(s0_stall), .stall_raw(s0_raw), .stall_waw(s0_waw),
      .long_busy_cnt(s0_busy)
   );

   scoreboard_hazard_unit #(.REG_ADDR_W(6), .SRC_NUM(3), .LAT_W(4), .BR_EXTRA(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .id_valid(in_v[1].valid), .id_src_addr(in_v[1].src),
      .id_src_used(in_v[1].used), .id_is_branch(in_v[1].br), .id_wreg(in_v[1].wreg),
      .id_dst_addr(in_v[1].dst), .id_lat(in_v[1].lat), .wb_valid(in_v[1].wbv), .wb_addr(in_v[1].wba),
      .flush(in_v[1].fl), .stall(s1_stall), .stall_raw(s1_raw), .stall_waw(s1_waw),
      .long_busy_cnt(s1_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int stk(int d);
      return (1 << LW[d]) - 1;
   endfunction

   function automatic int remaining(int d, int r);
      int x;
      x = ready[d][r] - cyc;
      return (x > 0) ? x : 0;
   endfunction

   function automatic bit exp_raw(int d);
      int a;
      int rm;
      if (!rst_n || !in_v[d].valid) return 1'b0;
      for (int k = 0; k < SN[d]; k++) begin
         a = int'(in_v[d].src[k]);
         if (in_v[d].used[k] && a != 0) begin
            if (sticky[d][a]) return 1'b1;
            rm = remaining(d, a);
            if (in_v[d].br ? (rm > 0) : (rm > BX[d])) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic bit exp_waw(int d);
      if (!rst_n || !in_v[d].valid || !in_v[d].wreg || in_v[d].dst == 6'd0) return 1'b0;
      return sticky[d][int'(in_v[d].dst)];
   endfunction

   function automatic int exp_busy(int d);
      int n;
      n = 0;
      for (int r = 1; r < (1 << AW[d]); r++) n += int'(sticky[d][r]);
      return n;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 64; r++) begin
            ready[d][r]  = 0;
            sticky[d][r] = 1'b0;
         end
      end
   endtask

   // Apply one clock edge to the model. This uses the inputs and the stall state that hold just before the edge.
   task automatic model_edge();
      bit st;
      bit rec;
      int dst;
      int lv;
      int wa;
      for (int d = 0; d < 2; d++) begin
         if (rst_n) begin
            st  = exp_raw(d) | exp_waw(d);
            dst = int'(in_v[d].dst);
            wa  = int'(in_v[d].wba);
            if (in_v[d].fl) begin
               for (int r = 0; r < 64; r++) begin
                  ready[d][r]  = 0;
                  sticky[d][r] = 1'b0;
               end
            end else begin
               rec = in_v[d].valid && !st && in_v[d].wreg && dst != 0;
               if (in_v[d].wbv && wa != 0 && sticky[d][wa] && !(rec && dst == wa)) begin
                  sticky[d][wa] = 1'b0;
                  ready[d][wa]  = 0;
               end
               if (rec) begin
                  if (int'(in_v[d].lat) == stk(d)) begin
                     sticky[d][dst] = 1'b1;
                  end else begin
                     lv = int'(in_v[d].lat) + BX[d];
                     if (lv > stk(d) - 1) lv = stk(d) - 1;
                     sticky[d][dst] = 1'b0;
                     ready[d][dst]  = cyc + 1 + lv;
                  end
               end
            end
         end
      end
      cyc++;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (model cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic compare_all();
      check("raw0",   int'(s0_raw),   int'(exp_raw(0)));
      check("waw0",   int'(s0_waw),   int'(exp_waw(0)));
      check("stall0", int'(s0_stall), int'(exp_raw(0) | exp_waw(0)));
      check("busy0",  int'(s0_busy),  exp_busy(0));
      check("raw1",   int'(s1_raw),   int'(exp_raw(1)));
      check("waw1",   int'(s1_waw),   int'(exp_waw(1)));
      check("stall1", int'(s1_stall), int'(exp_raw(1) | exp_waw(1)));
      check("busy1",  int'(s1_busy),  exp_busy(1));
   endtask

   // One cycle: compare at the negedge, advance the model, and return 1 ns after the posedge.
   task automatic tick(input int d, output bit st);
      @(negedge clk);
      compare_all();
      st = (d == 0) ? s0_stall : s1_stall;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int d);
      in_v[d] = '0;
   endtask

   task automatic set_instr(input int d, input int s0, input int s1, input int s2,
                            input logic [2:0] used, input bit br, input bit wreg,
                            input int dst, input int lat);
      in_v[d]        = '0;
      in_v[d].valid  = 1'b1;
      in_v[d].src[0] = 6'(s0);
      in_v[d].src[1] = 6'(s1);
      in_v[d].src[2] = 6'(s2);
      in_v[d].used   = used;
      in_v[d].br     = br;
      in_v[d].wreg   = wreg;
      in_v[d].dst    = 6'(dst);
      in_v[d].lat    = 4'(lat);
   endtask

   task automatic drain(input int n);
      bit st;
      idle(0);
      idle(1);
      for (int i = 0; i < n; i++) tick(0, st);
   endtask

   // Hold the ID instruction until it issues, then compare the number of stall cycles.
   task automatic measure(input int d, input int expn, input string nm);
      int n;
      bit st;
      bit done;
      n = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick(d, st);
         if (st) n++;
         else done = 1'b1;
      end
      check(nm, n, expn);
      idle(d);
   endtask

   task automatic rand_in(input int d);
      int amax;
      amax = (d == 0) ? 15 : 20;
      in_v[d].valid = ($urandom_range(0, 9) < 8);
      for (int k = 0; k < 3; k++) in_v[d].src[k] = 6'($urandom_range(0, amax));
      in_v[d].used = 3'($urandom_range(0, 7));
      in_v[d].br   = ($urandom_range(0, 3) == 0);
      in_v[d].wreg = ($urandom_range(0, 3) != 0);
      in_v[d].dst  = 6'($urandom_range(0, amax));
      in_v[d].lat  = ($urandom_range(0, 7) == 0) ? 4'(stk(d)) : 4'($urandom_range(0, stk(d) - 1));
      in_v[d].wbv  = ($urandom_range(0, 2) == 0);
      in_v[d].wba  = 6'($urandom_range(0, amax));
      in_v[d].fl   = ($urandom_range(0, 63) == 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit st;
      nchk = 0;
      nerr = 0;
      cyc  = 0;
      rst_n = 1'b0;
      idle(0);
      idle(1);
      model_reset();
      tick(0, st);
      tick(0, st);
      rst_n = 1'b1;
      check("rst_busy0", int'(s0_busy), 0);
      check("rst_stall0", int'(s0_stall), 0);

      // Load r2, then an ALU consumer: 1 stall cycle.
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 2, 1);
      tick(0, st);
      set_instr(0, 2, 1, 0, 3'b011, 1'b0, 1'b1, 3, 0);
      measure(0, 1, "load_alu");
      drain(4);
      // Load r2, then a branch consumer: 2 stall cycles.
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 2, 1);
      tick(0, st);
      set_instr(0, 2, 0, 0, 3'b011, 1'b1, 1'b0, 0, 0);
      measure(0, 2, "load_branch");
      drain(4);
      // ALU producer r7, then bne: 1 stall; then sub: 0 stalls.
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 7, 0);
      tick(0, st);
      set_instr(0, 7, 8, 0, 3'b011, 1'b1, 1'b0, 0, 0);
      measure(0, 1, "alu_branch");
      drain(4);
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 7, 0);
      tick(0, st);
      set_instr(0, 7, 8, 0, 3'b011, 1'b0, 1'b1, 9, 0);
      measure(0, 0, "alu_alu");
      drain(4);
      // A write to r0 is never tracked.
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 0, 1);
      tick(0, st);
      set_instr(0, 0, 0, 0, 3'b011, 1'b1, 1'b0, 0, 0);
      measure(0, 0, "r0_branch");
      drain(2);

      // div r10 is sticky: busy count, RAW hold, WAW, and release.
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 10, 7);
      tick(0, st);
      idle(0);
      tick(0, st);
      check("div_busy", int'(s0_busy), 1);
      set_instr(0, 10, 0, 0, 3'b001, 1'b0, 1'b1, 3, 0);
      for (int i = 0; i < 3; i++) begin
         tick(0, st);
         check("div_hold", int'(st), 1);
      end
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 10, 0);
      #2;
      check("div_waw", int'(s0_waw), 1);
      set_instr(0, 10, 0, 0, 3'b001, 1'b0, 1'b1, 3, 0);
      in_v[0].wbv = 1'b1;
      in_v[0].wba = 6'd10;
      tick(0, st);
      check("wb_edge_stall", int'(st), 1);
      in_v[0].wbv = 1'b0;
      tick(0, st);
      check("wb_released", int'(st), 0);
      drain(2);
      check("wb_busy0", int'(s0_busy), 0);

      // Release and a load issue to r11 in the same cycle: the count becomes 2.
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 11, 1);
      in_v[0].wbv = 1'b1;
      in_v[0].wba = 6'd11;
      tick(0, st);
      set_instr(0, 11, 0, 0, 3'b001, 1'b1, 1'b0, 0, 0);
      measure(0, 2, "wb_issue_same");
      drain(3);

      // A flush with three sticky registers clears everything.
      for (int r = 12; r <= 14; r++) begin
         set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, r, 7);
         tick(0, st);
      end
      idle(0);
      tick(0, st);
      check("flush_pre_busy", int'(s0_busy), 3);
      set_instr(0, 12, 13, 0, 3'b011, 1'b1, 1'b0, 0, 0);
      in_v[0].fl = 1'b1;
      tick(0, st);
      in_v[0].fl = 1'b0;
      check("flush_busy", int'(s0_busy), 0);
      tick(0, st);
      check("flush_nostall", int'(st), 0);
      drain(2);

      // Mid-run reset with r4 sticky and cnt[r5] = 2.
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 4, 7);
      tick(0, st);
      set_instr(0, 0, 0, 0, 3'b000, 1'b0, 1'b1, 5, 1);
      tick(0, st);
      set_instr(0, 4, 5, 0, 3'b011, 1'b1, 1'b1, 4, 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_stall", int'(s0_stall), 0);
      check("arst_raw", int'(s0_raw), 0);
      check("arst_waw", int'(s0_waw), 0);
      check("arst_busy", int'(s0_busy), 0);
      tick(0, st);
      rst_n = 1'b1;
      tick(0, st);
      check("post_rst_nostall", int'(st), 0);
      drain(2);

      // Swept instance: the third operand on a pending register causes a stall.
      set_instr(1, 0, 0, 0, 3'b000, 1'b0, 1'b1, 33, 1);
      tick(1, st);
      set_instr(1, 1, 2, 33, 3'b100, 1'b0, 1'b0, 0, 0);
      measure(1, 1, "sweep_op3");
      drain(4);
      // id_lat 14 saturates at 14 and does not become sticky.
      set_instr(1, 0, 0, 0, 3'b000, 1'b0, 1'b1, 40, 14);
      tick(1, st);
      check("sat_busy", int'(s1_busy), 0);
      set_instr(1, 40, 0, 0, 3'b001, 1'b1, 1'b0, 0, 0);
      measure(1, 14, "sat14_branch");
      drain(2);

      // Random phase: both instances are checked against the model on every cycle.
      for (int i = 0; i < 3000; i++) begin
         rand_in(0);
         rand_in(1);
         tick(0, st);
      end
      drain(2);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised scoreboard that generalises the pipeline load-use and branch hazard stalls.
- Holds one countdown per architectural register, so the stall decision comes from tracked producer latency, not fixed EXE/MEM stage compares.
- Sits in ID: checks up to SRC_NUM source operands of the instruction in ID against in-flight producers.
- Also covers variable-latency producers (mul/div, cache-miss loads), which hold a register busy until an explicit writeback release.

Parameters:
REG_ADDR_W, 5, register address width; register count = 2^REG_ADDR_W
SRC_NUM, 2, source operands checked per ID instruction
LAT_W, 3, counter width; code 2^LAT_W-1 (STICKY) = busy until released
BR_EXTRA, 1, extra cycles a branch/jump resolved in ID waits for an operand compared with an EXE consumer

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  instruction in ID is valid
id_src_addr  input  SRC_NUM*REG_ADDR_W  source register addresses; operand k at bits [k*REG_ADDR_W +: REG_ADDR_W]
id_src_used  input  SRC_NUM  per-operand "operand actually read"
id_is_branch  input  1  ID instruction resolves a branch/jump in ID
id_wreg  input  1  ID instruction writes a register
id_dst_addr  input  REG_ADDR_W  destination register
id_lat  input  LAT_W  cycles after issue until result is forwardable to an EXE consumer; STICKY = variable latency
wb_valid  input  1  variable-latency producer completed
wb_addr  input  REG_ADDR_W  register released by wb_valid
flush  input  1  pipeline flush (exception/eret); kills all tracked producers
stall  output  1  stall_raw | stall_waw
stall_raw  output  1  source operand not yet available
stall_waw  output  1  destination still held by a STICKY producer
long_busy_cnt  output  REG_ADDR_W+1  registered count of registers in STICKY state

Behaviour:
- State: cnt[r], LAT_W bits, for r = 1 .. 2^REG_ADDR_W-1. Register 0 is never tracked and never causes a stall.
- Reset (async, rst_n low):
  - all cnt = 0 and long_busy_cnt = 0;
  - stall, stall_raw and stall_waw forced 0 while rst_n is low.
- Issue condition: issue = id_valid & !stall & !flush. Issue also requires id_wreg and id_dst_addr != 0 to record a producer.
- Recording a producer at the clock edge (cnt[dst] <= ...):
  - id_lat == STICKY: cnt[dst] <= STICKY;
  - otherwise: cnt[dst] <= min(id_lat + BR_EXTRA, STICKY-1), computed at LAT_W+1 bits with no wrap.
- Countdown each edge for every other register:
  - cnt in 1 .. STICKY-1 decrements by 1;
  - 0 stays 0;
  - STICKY holds.
- Release: wb_valid with wb_addr != 0 sets cnt[wb_addr] = 0 only if it is STICKY. A release on a non-STICKY register is ignored.
- Same-cycle priority:
  - flush > issue > release > decrement;
  - an issue to register r beats a release of r in the same cycle.
- Flush: all cnt <= 0 at that edge, including STICKY ones; long_busy_cnt <= 0.
- stall_raw (combinational, current cnt): 1 when id_valid and some operand k has id_src_used[k] and addr != 0, plus one of:
  - id_is_branch == 0 and cnt[addr] > BR_EXTRA; or
  - id_is_branch == 1 and cnt[addr] != 0.
- STICKY always stalls either kind of consumer.
- stall_waw: id_valid & id_wreg & id_dst_addr != 0 & cnt[id_dst_addr] == STICKY.
- Resulting stall lengths:
  - ALU producer (id_lat 0): 0 stalls for an ALU consumer, 1 stall for a branch consumer;
  - load producer (id_lat 1): 1 stall for an ALU consumer, 2 stalls for a branch consumer.
- While stalled, nothing is recorded and counters keep decrementing.
- long_busy_cnt is updated at the same edge from the next-state count of STICKY registers.

Test Plan:
- Reset mid-run: STICKY on r4 plus cnt[r5] = 2, assert rst_n low asynchronously -> all outputs 0 immediately; after release, a consumer of r4 or r5 gets no stall.
- Load r2 (id_lat 1) issued at edge t, then "add r3,r2,r1" in ID -> stall_raw = 1 for exactly 1 cycle; as "beq r2,r0" in ID instead -> stall for exactly 2 cycles.
- ALU writes r7 (id_lat 0), then "bne r7,r8" -> 1 stall cycle; "sub r9,r7,r8" -> 0 stall cycles; source r0 with cnt[0] untracked -> never stalls.
- div writes r10 (STICKY): long_busy_cnt = 1; consumer of r10 stalls until wb_valid = 1, wb_addr = 10, and stall drops the cycle after that edge. A write to r10 during the busy window raises stall_waw.
- Same-cycle wb_valid (r11) and issue of a load to r11 -> cnt[r11] = 2, not 0. flush with 3 STICKY registers -> long_busy_cnt = 0 and no stalls the next cycle.
- Parameter sweep REG_ADDR_W = 6, SRC_NUM = 3, LAT_W = 4, BR_EXTRA = 2: third operand on a pending register stalls. id_lat = 14 saturates to cnt 14, not STICKY.
